eth_frame_gen: RTL and testbench
================================

Name: eth_frame_gen

Overview:
- AXI-stream Ethernet test-frame source feeding the TX stream input of the 1G GMII MAC/FIFO (eth_mac_1g_gmii_fifo) inside the chip top level.
- Emits fixed-format frames at a programmable cycle interval: header, 32-bit sequence number, deterministic fill pattern.
- Used for link bring-up and PHY/cable checks without CPU/DMA involvement.
- The MAC adds preamble, padding and FCS; this block emits header and payload only.

Parameters:
- DST_MAC, 48'hFFFFFFFFFFFF, destination MAC, sent MSB byte first.
- SRC_MAC, 48'h020000000001, source MAC, sent MSB byte first.
- ETHERTYPE, 16'h88B5, EtherType field, sent MSB byte first.
- PAYLOAD_LEN, 46, payload bytes per frame. Legal range 4..1500.
- INTERVAL, 32'd1249999, frame-start period is INTERVAL+1 clk cycles.

Ports:
- clk  in  1  system clock (CLK_OUT1 domain)
- resetn  in  1  synchronous active-low reset
- enable  in  1  level; frame scheduling allowed while high
- tx_axis_tdata  out  8  stream byte
- tx_axis_tvalid  out  1  stream valid
- tx_axis_tready  in  1  stream ready from MAC FIFO
- tx_axis_tlast  out  1  last byte of frame
- tx_axis_tuser  out  1  bad-frame flag to MAC
- frame_count  out  32  frames fully accepted; wraps
- drop_count  out  16  timer ticks lost to overrun; saturates at 16'hFFFF
- busy  out  1  high while state != IDLE

Behaviour:
- Reset: on a clk edge with resetn=0, all outputs go to 0, FSM goes to IDLE, timer loads INTERVAL, pending clears. Applies even mid-frame; the truncated frame is abandoned and the MAC FIFO discards it.
- Timer:
  - 32-bit down-counter; decrements every cycle while enable=1, holds while enable=0.
  - At 0, a tick is generated and the counter reloads INTERVAL on the next cycle.
- Tick handling:
  - Tick in IDLE: go to HDR next cycle.
  - Tick while busy with pending=0: set pending.
  - Tick while busy with pending=1: drop_count+1 (saturating).
- FSM states IDLE, HDR, PAY, DONE:
  - IDLE→HDR on tick, or on pending=1 with enable=1 (pending cleared). Captures seq = frame_count.
  - HDR: 14 beats, byte index 0..13 = DST_MAC[47:0], SRC_MAC, ETHERTYPE, MSB first. Last header handshake → PAY.
  - PAY: PAYLOAD_LEN beats, payload index k.
    - k<4: byte = seq[31-8k -: 8].
    - k>=4: byte = k[7:0].
    - tlast=1 only on k=PAYLOAD_LEN-1.
    - Handshake on the last beat → DONE.
  - DONE: single cycle, tvalid=0; frame_count+1; → IDLE. A pending frame starts on the following cycle.
- AXI rules:
  - Transfer occurs when tvalid && tready.
  - tvalid stays 1 for every beat from the first header byte to the last payload byte.
  - tdata, tlast and tuser hold stable while tvalid && !tready.
  - The byte counter advances only on a transfer.
  - tready may be low for any number of cycles; no beats are lost or duplicated.
- Enable deasserted mid-frame: the current frame completes normally; no new frame starts until enable=1.
- Latency: first header byte presented (tvalid=1) the cycle after leaving IDLE. Minimum frame-start to frame-start spacing is 14+PAYLOAD_LEN+2 cycles with tready=1.
- tuser=0 always unless the optional feature is compiled in.

Optional Feature:
- Macro: FRAMEGEN_ERR_INJECT_EN.
- Defined:
  - Adds input inject_err (1 bit).
  - A cycle with inject_err=1 sets a sticky arm flag.
  - The next frame to enter HDR captures the flag and clears it.
  - That frame drives tuser=1 on its tlast beat only. frame_count still increments.
- Undefined: no inject_err port; tuser constant 0.

Test Plan:
1. INTERVAL=99, PAYLOAD_LEN=46, enable=1, tready=1 → a 60-beat frame every 100 cycles.
   - Bytes 0–5 = FF, bytes 12–13 = 88 B5.
   - First frame's bytes 14–17 = 00 00 00 00, byte 18 = 04, last byte = 2D with tlast=1.
   - After 3 frames, frame_count=3.
2. Same as 1, tready toggling randomly at 50% → identical byte sequence; tdata stable during every stall; frame_count increments once per frame.
3. INTERVAL=9, PAYLOAD_LEN=46, tready=1 for 300 cycles → frames back-to-back with a 2-cycle gap; drop_count > 0 and saturating; frame 1 sequence bytes = 00 00 00 01.
4. resetn=0 for one cycle at beat 20 of a frame → next cycle tvalid=0, frame_count=0, busy=0; the next frame restarts at DST byte 0 after INTERVAL+1 cycles.
5. enable dropped at header beat 5 → frame finishes all 60 beats; no further tvalid while enable=0; the timer resumes from its held value when re-enabled.
6. (FRAMEGEN_ERR_INJECT_EN) pulse inject_err mid-frame N → frame N has tuser=0; frame N+1 has tuser=1 on tlast only; frame N+2 has tuser=0.

Source files
------------

// File: rtl/eth_frame_gen_if.sv
`default_nettype none
// =====================================================================
// Module  : eth_frame_gen_if
// Brief   : 8-bit AXI-stream TX bundle between frame source and MAC FIFO.
// Revision: 1.0
// =====================================================================
interface eth_frame_gen_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/eth_frame_gen.sv
`default_nettype none
// =====================================================================
// Module  : eth_frame_gen
// Brief   : Periodic AXI-stream Ethernet test-frame source (header, seq, fill).
//           Optional macro FRAMEGEN_ERR_INJECT_EN adds inject_err -> tuser.
// Revision: 1.0
// =====================================================================
module eth_frame_gen #(
    parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC     = 48'h020000000001,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          PAYLOAD_LEN = 46,
    parameter logic [31:0] INTERVAL    = 32'd1249999
) (
    input  wire             clk,
    input  wire             resetn,
    input  wire             enable,
`ifdef FRAMEGEN_ERR_INJECT_EN
    input  wire             inject_err,
`endif
    eth_frame_gen_if.master tx_axis,
    output logic [31:0]     frame_count,
    output logic [15:0]     drop_count,
    output logic            busy
);

    localparam logic [111:0] C_HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [10:0]  C_HDR_LAST = 11'd13;
    localparam logic [10:0]  C_PAY_LAST = 11'(PAYLOAD_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] timer_q;
    logic        pending_q;
    logic [10:0] cnt_q;
    logic [31:0] seq_q;
    logic [7:0]  tdata_q;
    logic        tvalid_q;
    logic        tlast_q;
    logic [31:0] frame_count_q;
    logic [15:0] drop_count_q;
`ifdef FRAMEGEN_ERR_INJECT_EN
    logic        arm_q;
    logic        err_frame_q;
    logic        tuser_q;
`endif

    logic        w_tick;
    logic        w_xfer;
    logic        w_start;
    logic [10:0] w_cnt_d;
    logic [7:0]  w_hdr_byte;
    logic [7:0]  w_pay_byte;

    function automatic logic [7:0] pay_byte(input logic [10:0] k, input logic [31:0] seq);
        logic [7:0] b;
        if (k < 11'd4) begin
            case (k[1:0])
                2'd0:    b = seq[31:24];
                2'd1:    b = seq[23:16];
                2'd2:    b = seq[15:8];
                default: b = seq[7:0];
            endcase
        end else begin
            b = k[7:0];
        end
        return b;
    endfunction

    assign w_tick  = enable && (timer_q == 32'd0);
    assign w_xfer  = tvalid_q && tx_axis.tready;
    assign w_start = w_tick || (pending_q && enable);
    assign w_cnt_d = cnt_q + 11'd1;

    always_comb begin
        w_hdr_byte = 8'h00;
        for (int b = 0; b < 14; b++) begin
            if (w_cnt_d[3:0] == 4'(b)) begin
                w_hdr_byte = C_HDR[8*(13-b) +: 8];
            end
        end
        w_pay_byte = pay_byte(w_cnt_d, seq_q);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            timer_q       <= INTERVAL;
            pending_q     <= 1'b0;
            cnt_q         <= 11'd0;
            seq_q         <= 32'd0;
            tdata_q       <= 8'h00;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            frame_count_q <= 32'd0;
            drop_count_q  <= 16'd0;
`ifdef FRAMEGEN_ERR_INJECT_EN
            arm_q         <= 1'b0;
            err_frame_q   <= 1'b0;
            tuser_q       <= 1'b0;
`endif
        end else begin
            if (enable) begin
                timer_q <= w_tick ? INTERVAL : timer_q - 32'd1;
            end
`ifdef FRAMEGEN_ERR_INJECT_EN
            arm_q <= arm_q | inject_err;
`endif
            case (state_q)
                S_IDLE: begin
                    if (w_start) begin
                        state_q   <= S_HDR;
                        // A tick landing on a pending start is carried over, not lost.
                        pending_q <= w_tick && pending_q;
                        seq_q     <= frame_count_q;
                        cnt_q     <= 11'd0;
                        tvalid_q  <= 1'b1;
                        tdata_q   <= C_HDR[111:104];
                        tlast_q   <= 1'b0;
`ifdef FRAMEGEN_ERR_INJECT_EN
                        err_frame_q <= arm_q;
                        arm_q       <= inject_err;
`endif
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        if (cnt_q == C_HDR_LAST) begin
                            state_q <= S_PAY;
                            cnt_q   <= 11'd0;
                            tdata_q <= seq_q[31:24];
                        end else begin
                            cnt_q   <= w_cnt_d;
                            tdata_q <= w_hdr_byte;
                        end
                    end
                end
                S_PAY: begin
                    if (w_xfer) begin
                        if (cnt_q == C_PAY_LAST) begin
                            state_q  <= S_DONE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            tdata_q  <= 8'h00;
`ifdef FRAMEGEN_ERR_INJECT_EN
                            tuser_q  <= 1'b0;
`endif
                        end else begin
                            cnt_q   <= w_cnt_d;
                            tdata_q <= w_pay_byte;
                            tlast_q <= (w_cnt_d == C_PAY_LAST);
`ifdef FRAMEGEN_ERR_INJECT_EN
                            tuser_q <= err_frame_q && (w_cnt_d == C_PAY_LAST);
`endif
                        end
                    end
                end
                S_DONE: begin
                    frame_count_q <= frame_count_q + 32'd1;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if ((state_q != S_IDLE) && w_tick) begin
                if (!pending_q) begin
                    pending_q <= 1'b1;
                end else if (drop_count_q != 16'hFFFF) begin
                    drop_count_q <= drop_count_q + 16'd1;
                end
            end
        end
    end

    assign tx_axis.tdata  = tdata_q;
    assign tx_axis.tvalid = tvalid_q;
    assign tx_axis.tlast  = tlast_q;
`ifdef FRAMEGEN_ERR_INJECT_EN
    assign tx_axis.tuser  = tuser_q;
`else
    assign tx_axis.tuser  = 1'b0;
`endif
    assign frame_count    = frame_count_q;
    assign drop_count     = drop_count_q;
    assign busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_gen.sv
`default_nettype none
// =====================================================================
// Module  : tb_eth_frame_gen
// Brief   : Scoreboard bench: frame-level reference model vs two DUTs (INTERVAL 99 / 9).
// Revision: 1.0
// =====================================================================
module tb_eth_frame_gen;
    localparam int PL = 46;
    localparam int FL = 14 + PL;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstn_a, rstn_b, en_a, en_b;
    logic [31:0] fc_a, fc_b;
    logic [15:0] dc_a, dc_b;
    logic        busy_a, busy_b;
`ifdef FRAMEGEN_ERR_INJECT_EN
    logic        inj_a;
`endif

    eth_frame_gen_if if_a ();
    eth_frame_gen_if if_b ();

    eth_frame_gen #(.PAYLOAD_LEN(PL), .INTERVAL(32'd99)) u_dut_a (
        .clk(clk), .resetn(rstn_a), .enable(en_a),
`ifdef FRAMEGEN_ERR_INJECT_EN
        .inject_err(inj_a),
`endif
        .tx_axis(if_a.master), .frame_count(fc_a), .drop_count(dc_a), .busy(busy_a)
    );

    eth_frame_gen #(.PAYLOAD_LEN(PL), .INTERVAL(32'd9)) u_dut_b (
        .clk(clk), .resetn(rstn_b), .enable(en_b),
`ifdef FRAMEGEN_ERR_INJECT_EN
        .inject_err(1'b0),
`endif
        .tx_axis(if_b.master), .frame_count(fc_b), .drop_count(dc_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    beat_t qa[$], qb[$];
    int    starts_a[$], starts_b[$];
    int    rst_cyc[2], beats[2], tlasts[2];
    bit    pv[2], pst[2];
    beat_t pbeat[2];
    beat_t g_a, g_b;

    assign g_a = {if_a.tdata, if_a.tlast, if_a.tuser};
    assign g_b = {if_b.tdata, if_b.tlast, if_b.tuser};

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference: one frame is header constants, then seq big-endian, then k-counter fill.
    function automatic beat_t model_beat(input int seq, input int i, input bit err);
        logic [7:0] hdr [14];
        beat_t b;
        int k;
        hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h88, 8'hB5};
        k = i - 14;
        if (i < 14)     b.d = hdr[i];
        else if (k < 4) b.d = 8'((seq >> (8 * (3 - k))) & 255);
        else            b.d = 8'(k);
        b.l = (k == PL - 1);
        b.u = err && b.l;
        return b;
    endfunction

    task automatic push_frames(input int w, input int first, input int n, input int err_seq);
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < FL; i++) begin
                if (w == 0) qa.push_back(model_beat(first + f, i, (first + f) == err_seq));
                else        qb.push_back(model_beat(first + f, i, (first + f) == err_seq));
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic mon(input int w, input logic rs, input logic v, input logic r, input beat_t g);
        beat_t e;
        bit    empty;
        if (!rs) begin
            pv[w]  = 1'b0;
            pst[w] = 1'b0;
            return;
        end
        if (pst[w]) begin
            checks++;
            if (!v || g !== pbeat[w]) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%0b beat=%0h expected v=1 beat=%0h", w, v, g, pbeat[w]);
            end
        end
        if (v && !pv[w]) begin
            if (w == 0) starts_a.push_back(cyc);
            else        starts_b.push_back(cyc);
        end
        if (v && r) begin
            checks++;
            empty = (w == 0) ? (qa.size() == 0) : (qb.size() == 0);
            if (empty) begin
                errors++;
                $display("FAIL beat[%0d]: got unexpected beat %0h, expected none", w, g);
            end else begin
                if (w == 0) e = qa.pop_front();
                else        e = qb.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL beat[%0d] #%0d: got %0h expected %0h", w, beats[w], g, e);
                end
            end
            beats[w]++;
            if (g.l) tlasts[w]++;
        end
        pv[w]    = v;
        pst[w]   = v && !r;
        pbeat[w] = g;
    endtask

    always @(negedge clk) begin
        mon(0, rstn_a, if_a.tvalid, if_a.tready, g_a);
        mon(1, rstn_b, if_b.tvalid, if_b.tready, g_b);
    end

    task automatic do_reset(input int w);
        if (w == 0) rstn_a = 1'b0;
        else        rstn_b = 1'b0;
        @(posedge clk); #1;
        rst_cyc[w] = cyc;
        if (w == 0) begin
            rstn_a = 1'b1; qa.delete(); starts_a.delete();
        end else begin
            rstn_b = 1'b1; qb.delete(); starts_b.delete();
        end
        beats[w]  = 0;
        tlasts[w] = 0;
    endtask

    task automatic wait_starts(input int w, input int n, input int budget);
        int t = 0;
        while (((w == 0) ? starts_a.size() : starts_b.size()) < n && t < budget) begin
            @(posedge clk); #1; t++;
        end
        chk($sformatf("wait_start%0d_dut%0d", n, w),
            32'(((w == 0) ? starts_a.size() : starts_b.size()) >= n), 32'd1);
    endtask

    task automatic wait_fc_a(input int n, input int budget);
        int t = 0;
        while (fc_a < 32'(n) && t < budget) begin
            @(posedge clk); #1; t++;
        end
        chk($sformatf("wait_frame_count_%0d", n), fc_a, 32'(n));
    endtask

    initial begin
        int s, d, prev_dc;
        bit mono;
        rstn_a = 1'b0; rstn_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
        if_a.tready = 1'b1; if_b.tready = 1'b1;
`ifdef FRAMEGEN_ERR_INJECT_EN
        inj_a = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        do_reset(0);
        chk("rst_tvalid", 32'(if_a.tvalid), 0);
        chk("rst_tlast_tuser", {30'd0, if_a.tlast, if_a.tuser}, 0);
        chk("rst_frame_count", fc_a, 0);
        chk("rst_drop_count", 32'(dc_a), 0);
        chk("rst_busy", 32'(busy_a), 0);

        // Periodic frames at full rate.
        push_frames(0, 0, 8, -1);
        wait_fc_a(3, 500);
        chk("t1_first_start", 32'(starts_a[0]), 32'(rst_cyc[0] + 100));
        chk("t1_period_1", 32'(starts_a[1] - starts_a[0]), 100);
        chk("t1_period_2", 32'(starts_a[2] - starts_a[1]), 100);
        chk("t1_beats_left", 32'(qa.size()), 32'(5 * FL));

        // Random backpressure: same byte stream, stall stability checked by the monitor.
        do_reset(0);
        push_frames(0, 0, 8, -1);
        for (int t = 0; t < 3000 && fc_a < 32'd4; t++) begin
            if_a.tready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        chk("t2_frame_count", fc_a, 4);
        chk("t2_tlast_count", 32'(tlasts[0]), 4);
        if_a.tready = 1'b1;

        // Reset mid-frame at beat 20.
        do_reset(0);
        push_frames(0, 0, 8, -1);
        for (int t = 0; t < 300 && beats[0] < 20; t++) begin
            @(posedge clk); #1;
        end
        chk("t4_at_beat20", 32'(beats[0]), 20);
        do_reset(0);
        chk("t4_tvalid", 32'(if_a.tvalid), 0);
        chk("t4_frame_count", fc_a, 0);
        chk("t4_busy", 32'(busy_a), 0);
        push_frames(0, 0, 8, -1);
        wait_starts(0, 1, 200);
        chk("t4_restart_time", 32'(starts_a[0]), 32'(rst_cyc[0] + 100));
        wait_fc_a(1, 100);

        // Enable dropped at header beat 5; timer holds while disabled.
        do_reset(0);
        push_frames(0, 0, 8, -1);
        wait_starts(0, 1, 200);
        s = starts_a[0];
        while (cyc < s + 5) begin
            @(posedge clk); #1;
        end
        d = $urandom_range(70, 200);
        en_a = 1'b0;
        repeat (d) @(posedge clk);
        #1;
        chk("t5_frame_done", fc_a, 1);
        chk("t5_no_new_start", 32'(starts_a.size()), 1);
        chk("t5_idle", 32'(busy_a), 0);
        en_a = 1'b1;
        wait_starts(0, 2, 400);
        chk("t5_resume_gap", 32'(starts_a[1] - s), 32'(100 + d));

`ifdef FRAMEGEN_ERR_INJECT_EN
        do_reset(0);
        push_frames(0, 0, 8, 1);
        wait_starts(0, 1, 200);
        repeat (10) @(posedge clk);
        #1;
        inj_a = 1'b1;
        @(posedge clk); #1;
        inj_a = 1'b0;
        wait_fc_a(3, 500);
`endif

        // Overrun: INTERVAL=9 forces back-to-back frames and drops.
        rstn_a = 1'b0;
        do_reset(1);
        push_frames(1, 0, 8, -1);
        mono = 1'b1;
        prev_dc = 0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk); #1;
            if (int'(dc_b) < prev_dc) mono = 1'b0;
            prev_dc = int'(dc_b);
        end
        chk("t3_first_start", 32'(starts_b[0]), 32'(rst_cyc[1] + 10));
        chk("t3_b2b_gap_1", 32'(starts_b[1] - starts_b[0]), 32'(FL + 2));
        chk("t3_b2b_gap_2", 32'(starts_b[2] - starts_b[1]), 32'(FL + 2));
        chk("t3_frame_count", fc_b, 4);
        chk("t3_drops_nonzero", 32'(dc_b != 16'd0), 1);
        chk("t3_drops_monotonic", 32'(mono), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
